bsg_stream_op_cell: RTL and testbench

- Parametrised successor to the team's single-stage empty cell.
- Keeps the same ready/valid input and valid/yumi output handshake, and drops into the same trace-replay bench.
- Adds configurable data width, an output buffer of configurable depth, and three selectable per-word operations: pass, invert, and block accumulate.

---
 rtl/bsg_stream_op_cell_pkg.sv | 16 +
 rtl/bsg_stream_op_cell_fifo.sv | 55 +++++
 rtl/bsg_stream_op_cell.sv | 109 ++++++++++
 tb/tb_bsg_stream_op_cell.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/bsg_stream_op_cell_pkg.sv
// Shared types for the stream operation cell: operation select and block FSM states.
package bsg_stream_op_cell_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_INV  = 2'b01,
    MODE_ACC  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

endpackage

// File: rtl/bsg_stream_op_cell_fifo.sv
// Circular output buffer: ready/valid enqueue, valid/yumi dequeue, occupancy-based full/empty.
module bsg_stream_op_cell_fifo #(
  parameter int unsigned width_p = 10,
  parameter int unsigned els_p   = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [width_p-1:0]           data_i,
  input  logic                         v_i,
  output logic                         ready_o,
  output logic [width_p-1:0]           data_o,
  output logic                         v_o,
  input  logic                         yumi_i,
  output logic [$clog2(els_p+1)-1:0]   count_o
);

  localparam int unsigned ptr_w = $clog2(els_p);
  localparam int unsigned cnt_w = $clog2(els_p + 1);

  logic [width_p-1:0] mem [els_p];
  logic [ptr_w-1:0]   rptr;
  logic [ptr_w-1:0]   wptr;
  logic [cnt_w-1:0]   count;
  logic               enq;
  logic               deq;

  assign ready_o = reset_n_i & (count != cnt_w'(els_p));
  assign v_o     = (count != '0);
  assign data_o  = mem[rptr];
  assign count_o = count;
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  // Pointers wrap naturally because els_p is a power of two.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (enq) wptr <= wptr + ptr_w'(1);
      if (deq) rptr <= rptr + ptr_w'(1);
      case ({enq, deq})
        2'b10:   count <= count + cnt_w'(1);
        2'b01:   count <= count - cnt_w'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem[wptr] <= data_i;
  end

endmodule

// File: rtl/bsg_stream_op_cell.sv
// Stream cell applying pass / invert / block-accumulate to each accepted word ahead of an output buffer.
module bsg_stream_op_cell
  import bsg_stream_op_cell_pkg::*;
#(
  parameter int unsigned width_p     = 10,
  parameter int unsigned els_p       = 4,
  parameter int unsigned block_len_p = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [1:0]                   mode_i,
  input  logic [width_p-1:0]           data_i,
  input  logic                         v_i,
  output logic                         ready_o,
  output logic [width_p-1:0]           data_o,
  output logic                         v_o,
  input  logic                         yumi_i,
  output logic [$clog2(els_p+1)-1:0]   count_o,
  output logic                         ovf_o
);

  localparam int unsigned beat_w = (block_len_p > 1) ? $clog2(block_len_p) : 1;

  state_e              state, state_n;
  logic [width_p-1:0]  acc, acc_n;
  logic [beat_w-1:0]   beat, beat_n;
  logic                ovf, ovf_n;
  logic                accept;
  logic                last_beat;
  logic [width_p:0]    acc_sum;
  mode_e               eff_mode;
  logic                enq_v;
  logic [width_p-1:0]  enq_data;

  assign accept    = v_i & ready_o;
  assign acc_sum   = {1'b0, acc} + {1'b0, data_i};
  assign last_beat = (beat == beat_w'(block_len_p - 1));
  assign eff_mode  = (state == ACCUM) ? MODE_ACC : mode_e'(mode_i);
  assign ovf_o     = ovf;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= IDLE;
      acc   <= '0;
      beat  <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      beat  <= beat_n;
      ovf   <= ovf_n;
    end
  end

  // Per-word operation and block sequencing; the buffer only sees completed words.
  always_comb begin
    state_n  = state;
    acc_n    = acc;
    beat_n   = beat;
    ovf_n    = ovf;
    enq_v    = 1'b0;
    enq_data = data_i;
    if (accept) begin
      case (eff_mode)
        MODE_INV: begin
          enq_v    = 1'b1;
          enq_data = ~data_i;
        end
        MODE_ACC: begin
          if (block_len_p == 1) begin
            enq_v = 1'b1;
          end else begin
            ovf_n = ovf | acc_sum[width_p];
            if (last_beat) begin
              enq_v    = 1'b1;
              enq_data = acc_sum[width_p-1:0];
              acc_n    = '0;
              beat_n   = '0;
              state_n  = IDLE;
            end else begin
              acc_n   = acc_sum[width_p-1:0];
              beat_n  = beat + beat_w'(1);
              state_n = ACCUM;
            end
          end
        end
        default: enq_v = 1'b1;
      endcase
    end
  end

  bsg_stream_op_cell_fifo #(
    .width_p (width_p),
    .els_p   (els_p)
  ) u_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .data_i    (enq_data),
    .v_i       (enq_v),
    .ready_o   (ready_o),
    .data_o    (data_o),
    .v_o       (v_o),
    .yumi_i    (yumi_i),
    .count_o   (count_o)
  );

  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);

endmodule

// File: tb/tb_bsg_stream_op_cell.sv
// Self-checking bench for bsg_stream_op_cell against a queue-based reference model.
module tb_bsg_stream_op_cell;

  logic       clk_i = 1'b0;
  logic       reset_n_i;
  logic [1:0] mode_i;
  logic [9:0] data_i;
  logic       v_i;
  logic       ready_o;
  logic [9:0] data_o;
  logic       v_o;
  logic       yumi_i;
  logic [2:0] count_o;
  logic       ovf_o;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [9:0] mq[$];
  int         m_acc;
  int         m_beat;
  bit         m_in_blk;
  bit         m_ovf;

  always #5 clk_i = ~clk_i;

  bsg_stream_op_cell #(.width_p(10), .els_p(4), .block_len_p(4)) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .mode_i    (mode_i),
    .data_i    (data_i),
    .v_i       (v_i),
    .ready_o   (ready_o),
    .data_o    (data_o),
    .v_o       (v_o),
    .yumi_i    (yumi_i),
    .count_o   (count_o),
    .ovf_o     (ovf_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_acc    = 0;
    m_beat   = 0;
    m_in_blk = 0;
    m_ovf    = 0;
  endtask

  task automatic check_outputs();
    chk("v_o", 32'(v_o), 32'(mq.size() != 0));
    chk("count_o", 32'(count_o), 32'(mq.size()));
    chk("ready_o", 32'(ready_o), 32'(mq.size() < 4));
    chk("ovf_o", 32'(ovf_o), 32'(m_ovf));
    if (mq.size() != 0) chk("data_o", 32'(data_o), 32'(mq[0]));
  endtask

  // One clock: check outputs, drive inputs at negedge, advance the model across the posedge.
  task automatic cycle(input logic v, input logic [9:0] d, input logic [1:0] m,
                       input logic want_y, output bit accepted);
    bit   rdy;
    bit   y;
    int   eff;
    int   s;
    check_outputs();
    rdy = (mq.size() < 4);
    y   = want_y && (mq.size() != 0);
    v_i = v; data_i = d; mode_i = m; yumi_i = y;
    accepted = v && rdy;
    if (y) void'(mq.pop_front());
    if (accepted) begin
      eff = m_in_blk ? 2 : int'(m);
      if (eff == 1) mq.push_back(~d);
      else if (eff == 2) begin
        s = m_acc + int'(d);
        if (s >= 1024) m_ovf = 1;
        if (m_beat == 3) begin
          mq.push_back(10'(s % 1024));
          m_acc = 0; m_beat = 0; m_in_blk = 0;
        end else begin
          m_acc = s % 1024; m_beat++; m_in_blk = 1;
        end
      end else mq.push_back(d);
    end
    @(negedge clk_i);
  endtask

  task automatic send(input logic [9:0] d, input logic [1:0] m, input logic want_y);
    bit a;
    int tries;
    tries = 0;
    do begin
      cycle(1'b1, d, m, want_y, a);
      tries++;
    end while (!a && tries < 20);
    if (!a) chk("send_timeout", 32'(tries), 32'(0));
  endtask

  task automatic idle(input int n, input logic want_y);
    bit a;
    for (int i = 0; i < n; i++) cycle(1'b0, 10'h0, 2'b00, want_y, a);
  endtask

  initial begin
    bit a;
    logic [9:0] d;
    reset_n_i = 1'b0;
    v_i = 1'b0; data_i = '0; mode_i = '0; yumi_i = 1'b0;
    model_clear();
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rst_v_o", 32'(v_o), 32'(0));
    chk("rst_count_o", 32'(count_o), 32'(0));
    chk("rst_ready_o", 32'(ready_o), 32'(0));
    chk("rst_ovf_o", 32'(ovf_o), 32'(0));
    reset_n_i = 1'b1;
    @(negedge clk_i);

    // Pass and invert
    send(10'h001, 2'b00, 1'b1);
    send(10'h3FF, 2'b00, 1'b1);
    send(10'h155, 2'b00, 1'b1);
    idle(2, 1'b1);
    send(10'h000, 2'b01, 1'b1);
    send(10'h155, 2'b01, 1'b1);
    idle(2, 1'b1);

    // Accumulate: normal block then a block that carries out
    send(10'd1, 2'b10, 1'b1);
    send(10'd2, 2'b10, 1'b1);
    send(10'd3, 2'b10, 1'b1);
    send(10'd4, 2'b10, 1'b1);
    idle(2, 1'b1);
    send(10'h3FF, 2'b10, 1'b1);
    send(10'h001, 2'b10, 1'b1);
    send(10'h000, 2'b10, 1'b1);
    send(10'h000, 2'b10, 1'b1);
    idle(2, 1'b1);
    chk("ovf_sticky", 32'(ovf_o), 32'(1));

    // Backpressure: fill, get refused, then drain
    for (int i = 0; i < 4; i++) cycle(1'b1, 10'(8'h40 + i), 2'b00, 1'b0, a);
    cycle(1'b1, 10'h044, 2'b00, 1'b0, a);
    cycle(1'b1, 10'h044, 2'b00, 1'b0, a);
    chk("full_ready_o", 32'(ready_o), 32'(0));
    chk("full_count_o", 32'(count_o), 32'(4));
    send(10'h044, 2'b00, 1'b1);
    send(10'h045, 2'b00, 1'b1);
    idle(6, 1'b1);

    // Mode change mid-block: ACCUM ignores mode_i until the block completes
    send(10'd5, 2'b10, 1'b1);
    send(10'd6, 2'b10, 1'b1);
    send(10'd7, 2'b00, 1'b1);
    send(10'd8, 2'b00, 1'b1);
    send(10'd9, 2'b00, 1'b1);
    idle(3, 1'b1);

    // Asynchronous reset with buffered words and a partial block
    send(10'd1, 2'b00, 1'b0);
    send(10'd2, 2'b00, 1'b0);
    send(10'd3, 2'b10, 1'b0);
    #2 reset_n_i = 1'b0;
    #1;
    chk("arst_v_o", 32'(v_o), 32'(0));
    chk("arst_count_o", 32'(count_o), 32'(0));
    chk("arst_ready_o", 32'(ready_o), 32'(0));
    chk("arst_ovf_o", 32'(ovf_o), 32'(0));
    model_clear();
    v_i = 1'b0; yumi_i = 1'b0;
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    send(10'd1, 2'b10, 1'b1);
    send(10'd2, 2'b10, 1'b1);
    send(10'd3, 2'b10, 1'b1);
    send(10'd4, 2'b10, 1'b1);
    idle(2, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      d = ($urandom_range(0, 3) == 0) ? 10'h3FF : 10'($urandom());
      cycle($urandom_range(0, 3) != 0, d, 2'($urandom()), $urandom_range(0, 3) != 0, a);
    end
    idle(6, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
